// File: rtl/cpu_host_pkg.sv
// Shared definitions for the CPU host command sequencer: cmd bit layout,
// host operation codes and sequencer states.
package cpu_host_pkg;

  localparam int PIPE_EN_BIT = 31;
  localparam int REQ_BIT     = 30;
  localparam int RW_BIT      = 29;
  localparam int SRST_BIT    = 28;
  localparam int ADDR_MSB    = 7;

  localparam logic [31:0] RUN_CMD  = 32'h1 << PIPE_EN_BIT;
  localparam logic [31:0] CRST_CMD = 32'h1 << SRST_BIT;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_CRST  = 2'b10,
    OP_RUN   = 2'b11
  } op_type_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CRST,
    ST_RUN
  } state_t;

  // Memory access command: req set, rw selects read, address in the low byte.
  function automatic logic [31:0] mem_cmd(input logic rd, input logic [ADDR_MSB:0] addr);
    logic [31:0] c;
    c               = '0;
    c[REQ_BIT]      = 1'b1;
    c[RW_BIT]       = rd;
    c[ADDR_MSB:0]   = addr;
    return c;
  endfunction

endpackage

// File: rtl/cpu_host_if_hold_counter.sv
// 32-bit loadable down-counter timing the multi-cycle READ, CRST and RUN states.
// last flags the final cycle of a hold (count == 1); the count parks at 0.
module hold_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        en,
  output logic        last
);

  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != 32'd0)) begin
      cnt <= cnt - 32'd1;
    end
  end

  assign last = (cnt == 32'd1);

endmodule

// File: rtl/cpu_host_if.sv
// Host-side command sequencer: turns single WRITE/READ/CPU_RESET/RUN host
// operations into timed cmd_in/din sequences and captures the CPU read returns.
module cpu_host_if
  import cpu_host_pkg::*;
#(
  parameter int RD_HOLD    = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  // Handshake: an operation transfers on a rising edge where op_valid & op_ready;
  // op_ready is high only in IDLE, the host holds op_valid and its fields until
  // then, and rsp_valid is a single-cycle pulse with no backpressure.
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_type,
  input  logic [7:0]  op_addr,
  input  logic [63:0] op_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] cpu_cmd,
  output logic [31:0] cpu_din_low,
  output logic [31:0] cpu_din_high,
  input  logic [31:0] cpu_cmd_echo,
  input  logic [31:0] cpu_dout_low,
  input  logic [31:0] cpu_dout_high,
  output state_t      dbg_state
);

  state_t      state, state_n;
  logic [7:0]  addr_q;
  logic [31:0] cmd_n, din_low_n, din_high_n;
  logic        rsp_valid_n, capture, accept;
  logic        cnt_load, cnt_last;
  logic [31:0] cnt_load_val;

  assign accept    = op_valid && op_ready;
  assign dbg_state = state;

  hold_counter u_hold_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (state != ST_IDLE),
    .last     (cnt_last)
  );

  // Next-state logic also computes the value every registered output takes next.
  always_comb begin
    state_n      = state;
    cmd_n        = '0;
    din_low_n    = '0;
    din_high_n   = '0;
    rsp_valid_n  = 1'b0;
    capture      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (op_type_t'(op_type))
            OP_WRITE: begin
              state_n    = ST_WRITE;
              cmd_n      = mem_cmd(1'b0, op_addr);
              din_low_n  = op_wdata[31:0];
              din_high_n = op_wdata[63:32];
            end
            OP_READ: begin
              state_n      = ST_READ;
              cmd_n        = mem_cmd(1'b1, op_addr);
              cnt_load     = 1'b1;
              cnt_load_val = 32'(RD_HOLD + 1);
            end
            OP_CRST: begin
              state_n      = ST_CRST;
              cmd_n        = CRST_CMD;
              cnt_load     = 1'b1;
              cnt_load_val = 32'(RST_CYCLES);
            end
            OP_RUN: begin
              // A zero-length run completes at once without touching pipeline_en.
              if (op_wdata[31:0] == 32'd0) begin
                rsp_valid_n = 1'b1;
              end else begin
                state_n      = ST_RUN;
                cmd_n        = RUN_CMD;
                cnt_load     = 1'b1;
                cnt_load_val = op_wdata[31:0];
              end
            end
            default: ;
          endcase
        end
      end
      ST_WRITE: begin
        state_n     = ST_IDLE;
        rsp_valid_n = 1'b1;
      end
      ST_READ: begin
        if (cnt_last) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b1;
          capture     = 1'b1;
        end else begin
          cmd_n = mem_cmd(1'b1, addr_q);
        end
      end
      ST_CRST: begin
        if (cnt_last) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b1;
        end else begin
          cmd_n = CRST_CMD;
        end
      end
      ST_RUN: begin
        if (cnt_last) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b1;
        end else begin
          cmd_n = RUN_CMD;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      op_ready     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      cpu_cmd      <= '0;
      cpu_din_low  <= '0;
      cpu_din_high <= '0;
    end else begin
      state        <= state_n;
      op_ready     <= (state_n == ST_IDLE);
      rsp_valid    <= rsp_valid_n;
      cpu_cmd      <= cmd_n;
      cpu_din_low  <= din_low_n;
      cpu_din_high <= din_high_n;
      if (accept) begin
        addr_q <= op_addr;
      end
      // The echo of the last hold cycle must match the command still being driven.
      rsp_err <= capture && (cpu_cmd_echo != cpu_cmd);
      if (capture) begin
        rsp_rdata <= {cpu_dout_high, cpu_dout_low};
      end
    end
  end

endmodule

// File: tb/tb_cpu_host_if.sv
// Directed bench for cpu_host_if against a small behavioural CPU register
// interface (memory, echo, pc) with a response scoreboard.
module tb_cpu_host_if;
  import cpu_host_pkg::*;

  logic        clk, rst;
  logic        op_valid, op_ready;
  logic [1:0]  op_type;
  logic [7:0]  op_addr;
  logic [63:0] op_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic [31:0] cpu_cmd, cpu_din_low, cpu_din_high;
  logic [31:0] cpu_cmd_echo, cpu_dout_low, cpu_dout_high;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pipe_cnt = 0, srst_cnt = 0, both_cnt = 0;
  logic [64:0] exp_q[$];

  // Behavioural CPU side
  logic [63:0] mem [256];
  logic [31:0] cmd_out_q;
  logic        corrupt_echo;
  int          pc_model;

  cpu_host_if #(.RD_HOLD(2), .RST_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_type      (op_type),
    .op_addr      (op_addr),
    .op_wdata     (op_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .cpu_cmd      (cpu_cmd),
    .cpu_din_low  (cpu_din_low),
    .cpu_din_high (cpu_din_high),
    .cpu_cmd_echo (cpu_cmd_echo),
    .cpu_dout_low (cpu_dout_low),
    .cpu_dout_high(cpu_dout_high),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- CPU model ----------------
  assign cpu_cmd_echo = cmd_out_q ^ (corrupt_echo ? 32'h2000_0000 : 32'h0);

  always @(posedge clk) begin
    cmd_out_q <= cpu_cmd;
    if (cpu_cmd[30] && !cpu_cmd[29]) mem[cpu_cmd[7:0]] <= {cpu_din_high, cpu_din_low};
    if (cpu_cmd[30] && cpu_cmd[29]) {cpu_dout_high, cpu_dout_low} <= mem[cpu_cmd[7:0]];
    else {cpu_dout_high, cpu_dout_low} <= 64'h0;
    if (cpu_cmd[28]) pc_model <= 0;
    else if (cpu_cmd[31]) pc_model <= pc_model + 1;
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (cpu_cmd[31] && cpu_cmd[30]) both_cnt++;
    if (cpu_cmd[31]) pipe_cnt++;
    if (cpu_cmd[28]) srst_cnt++;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=rsp_valid=1 expected=no response (cycle %0d)", cyc);
      end else begin
        check("rsp_err_rdata", {rsp_err, rsp_rdata}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge where rsp_valid is seen.
  task automatic do_op(input logic [1:0] op, input logic [7:0] addr, input logic [63:0] wdata,
                       output int lat, output int acc_cyc, output int rsp_cyc);
    int guard;
    op_valid = 1'b1;
    op_type  = op;
    op_addr  = addr;
    op_wdata = wdata;
    guard = 0;
    while (!op_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!op_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=op_ready=0 expected=op_ready=1 within 200 cycles");
    end
    acc_cyc = cyc;
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    rsp_cyc = cyc;
    if (!rsp_valid) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout actual=no rsp_valid expected=rsp_valid within 300 cycles");
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic        corrupt;
    int          exp_lat;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_pipe;
    int          exp_srst;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, acc_c, rsp_c, prev_rsp;

    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    cmd_out_q = '0; cpu_dout_low = '0; cpu_dout_high = '0; pc_model = 0;
    corrupt_echo = 1'b0;
    rst = 1'b1; op_valid = 1'b0; op_type = 2'b00; op_addr = '0; op_wdata = '0;

    vecs[0] = '{2'b00, 8'h05, 64'hDEAD_BEEF_0123_4567, 1'b0, 2, 64'h0, 1'b0, 0, 0};
    vecs[1] = '{2'b01, 8'h05, 64'h0, 1'b0, 4, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 0};
    vecs[2] = '{2'b00, 8'h0A, 64'h0000_0001_0000_0002, 1'b0, 2, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 0};
    vecs[3] = '{2'b01, 8'h0A, 64'h0, 1'b0, 4, 64'h0000_0001_0000_0002, 1'b0, 0, 0};
    vecs[4] = '{2'b01, 8'hFF, 64'h0, 1'b0, 4, 64'h0, 1'b0, 0, 0};
    vecs[5] = '{2'b01, 8'h05, 64'h0, 1'b1, 4, 64'hDEAD_BEEF_0123_4567, 1'b1, 0, 0};
    vecs[6] = '{2'b11, 8'h00, 64'h0, 1'b0, 1, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 0};
    vecs[7] = '{2'b11, 8'h00, 64'hFFFF_FFFF_0000_0007, 1'b0, 8, 64'hDEAD_BEEF_0123_4567, 1'b0, 7, 0};
    vecs[8] = '{2'b10, 8'h00, 64'h0, 1'b0, 5, 64'hDEAD_BEEF_0123_4567, 1'b0, 0, 4};
    vecs[9] = '{2'b11, 8'h00, 64'h0000_0000_0000_0003, 1'b0, 4, 64'hDEAD_BEEF_0123_4567, 1'b0, 3, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_cpu_cmd", {33'h0, cpu_cmd}, 65'h0);
    check("reset_din", {1'b0, cpu_din_high, cpu_din_low}, 65'h0);
    check("reset_op_ready", {64'h0, op_ready}, 65'h0);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata[62:0]}, 65'h0);
    rst = 1'b0;
    @(negedge clk);
    check("op_ready_after_reset", {64'h0, op_ready}, 65'h1);

    // Reset mid-RUN(N=100): abort without response
    op_valid = 1'b1; op_type = 2'b11; op_addr = 8'h00; op_wdata = 64'd100;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("run_in_progress", {33'h0, cpu_cmd}, {33'h0, 32'h8000_0000});
    rst = 1'b1;
    @(negedge clk);
    check("abort_cpu_cmd", {33'h0, cpu_cmd}, 65'h0);
    check("abort_op_ready", {64'h0, op_ready}, 65'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_release_op_ready", {64'h0, op_ready}, 65'h1);
    check("abort_state_idle", {62'h0, dbg_state}, {62'h0, ST_IDLE});
    repeat (3) @(negedge clk);
    check("abort_cmd_idle", {33'h0, cpu_cmd}, 65'h0);

    // Table-driven operations, issued back-to-back
    prev_rsp = -1;
    foreach (vecs[i]) begin
      corrupt_echo = vecs[i].corrupt;
      exp_q.push_back({vecs[i].exp_err, vecs[i].exp_rdata});
      pipe_cnt = 0;
      srst_cnt = 0;
      do_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, acc_c, rsp_c);
      check($sformatf("v%0d_latency", i), 65'(lat), 65'(vecs[i].exp_lat));
      check($sformatf("v%0d_pipe_cycles", i), 65'(pipe_cnt), 65'(vecs[i].exp_pipe));
      check($sformatf("v%0d_srst_cycles", i), 65'(srst_cnt), 65'(vecs[i].exp_srst));
      if (i > 0) check($sformatf("v%0d_back_to_back", i), 65'(acc_c), 65'(prev_rsp));
      prev_rsp = rsp_c;
    end
    corrupt_echo = 1'b0;

    // Back-to-back WRITE then READ: command must appear in the cycle after rsp_valid
    exp_q.push_back({1'b0, 64'hDEAD_BEEF_0123_4567});
    do_op(2'b00, 8'h33, 64'h0123_4567_89AB_CDEF, lat, acc_c, rsp_c);
    op_valid = 1'b1; op_type = 2'b01; op_addr = 8'h33; op_wdata = '0;
    @(negedge clk);
    op_valid = 1'b0;
    check("b2b_read_cmd_no_bubble", {33'h0, cpu_cmd}, {33'h0, 32'h6000_0033});
    exp_q.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
    repeat (3) @(negedge clk);
    check("b2b_read_rsp_valid", {64'h0, rsp_valid}, 65'h1);
    @(negedge clk);

    // After CPU_RESET then RUN N=3 the CPU pc must be 3
    check("pc_after_reset_run", 65'(pc_model), 65'd3);
    check("req_pipe_exclusive", 65'(both_cnt), 65'd0);
    check("scoreboard_drained", 65'(exp_q.size()), 65'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_host_if.md
# cpu_host_if

Host-side command sequencer for the CPU's register interface. Accepts single memory write, memory read, CPU-reset and run-for-N-cycles operations from a host port. Converts each one into the timed `cmd_in`/`din_low`/`din_high` sequence the CPU expects. Captures the registered `cmd_out`/`dout_*` returns, so the CPU memory can be loaded, run and inspected without toggling command bits by hand.

## Interface
- `RD_HOLD`, default 2: extra cycles a read command is held after the first; must be ≥1.
- `RST_CYCLES`, default 4: cycles the CPU soft reset (cmd bit 28) is asserted.
- `clk` in 1: single clock, shared with the CPU.
- `rst` in 1: synchronous, active-high reset.
- `op_valid` in 1: host operation request.
- `op_ready` out 1: high only in IDLE; the operation is accepted on `op_valid & op_ready`.
- `op_type` in 2: operation code.
  - 00 = WRITE
  - 01 = READ
  - 10 = CPU_RESET
  - 11 = RUN
- `op_addr` in 8: memory address field, placed in cmd[7:0].
- `op_wdata` in 64: write data for WRITE; bits [31:0] give the cycle count N for RUN.
- `rsp_valid` out 1: one-cycle completion pulse. There is no backpressure.
- `rsp_rdata` out 64: read data. Updated only on READ completion; holds its value otherwise.
- `rsp_err` out 1: valid with `rsp_valid`. Set to 1 when the read echo check fails.
- `cpu_cmd` out 32: drives the CPU `cmd_in`.
  - [31] pipeline_en
  - [30] req
  - [29] rw (1 = read)
  - [28] soft reset
  - [7:0] addr
  - all other bits 0
- `cpu_din_low`, `cpu_din_high` out 32 each: drive the CPU `din_low`/`din_high`.
- `cpu_cmd_echo` in 32: CPU `cmd_out`, which is `cmd_in` delayed one cycle.
- `cpu_dout_low`, `cpu_dout_high` in 32 each: CPU `dout_low`/`dout_high`, registered, zero unless the previous cycle was a read request.

## Operation
- FSM states: IDLE, WRITE, READ, CRST, RUN. All outputs are registered.
- Reset values:
  - state = IDLE.
  - `cpu_cmd`, `cpu_din_*`, `rsp_rdata`, `rsp_valid`, `rsp_err` = 0.
  - `op_ready` = 0 during the reset cycle and 1 from the first cycle after reset.
- `rst` asserted in any state aborts the operation without a response. The next cycle drives `cpu_cmd` = 0.
- Invariant: req (bit 30) and pipeline_en (bit 31) are never 1 in the same cycle.
- IDLE:
  - `cpu_cmd` = 0 and `cpu_din_*` = 0.
  - On accept, latch the operation and branch on `op_type`.
- WRITE:
  - For 1 cycle, `cpu_cmd` = {3'b010, 0, 20'b0, addr} and `cpu_din` = wdata.
  - Then go to IDLE with `rsp_valid`=1 and `rsp_err`=0.
- READ:
  - For RD_HOLD+1 cycles, `cpu_cmd` = {3'b011, 0, 20'b0, addr}.
  - At the edge closing the last hold cycle, capture {`cpu_dout_high`, `cpu_dout_low`} into `rsp_rdata`.
  - Set `rsp_err` = (`cpu_cmd_echo` != `cpu_cmd`), sampled in that same cycle.
  - Then go to IDLE with `rsp_valid`.
- CRST:
  - For RST_CYCLES cycles, `cpu_cmd` = 32'h1000_0000.
  - Then go to IDLE with `rsp_valid`.
- RUN:
  - N == 0: return to IDLE on the next cycle with `rsp_valid`, and never assert pipeline_en.
  - N > 0: `cpu_cmd` = 32'h8000_0000 for exactly N cycles, then go to IDLE with `rsp_valid`.
  - N = 32'hFFFF_FFFF is legal. The counter must not wrap early.
- Hold counter: 32 bits, loaded on accept, decrements once per cycle, and the state exits when it reaches 1.
- `op_valid` in a non-IDLE state is ignored. The host must hold it until it sees `op_ready`.

## Timing
Operation accepted at cycle T:
- WRITE: command driven at T+1; `rsp_valid` at T+2.
- READ (RD_HOLD=2): command driven at T+1..T+3; data captured at the end of T+3; `rsp_valid` and `rsp_rdata` at T+4.
- CPU_RESET: bit 28 high at T+1..T+RST_CYCLES; `rsp_valid` at T+RST_CYCLES+1.
- RUN: pipeline_en high at T+1..T+N; `rsp_valid` at T+N+1. For N=0, `rsp_valid` at T+1.
- `op_ready` rises in the same cycle as `rsp_valid`, so back-to-back operations are possible: the next accept can happen in the `rsp_valid` cycle.

## Structure
- Package `cpu_host_pkg` holds:
  - cmd bit positions: PIPE_EN_BIT=31, REQ_BIT=30, RW_BIT=29, SRST_BIT=28, ADDR_MSB=7.
  - the `op_type` enum.
  - the FSM state enum.
- One sub-module, `hold_counter`: a 32-bit loadable down-counter with a `last` flag, shared by the READ, CRST and RUN states.

## Test plan
- Reset: hold `rst` for 3 cycles mid-RUN with N=100 → `cpu_cmd`=0 one cycle later, no `rsp_valid`, `op_ready`=1 after release.
- WRITE addr=8'h05, wdata=64'hDEAD_BEEF_0123_4567, then READ addr=8'h05 against the real CPU → `rsp_rdata`=64'hDEAD_BEEF_0123_4567, `rsp_err`=0, `rsp_valid` at T+4.
- READ with a bench-corrupted `cpu_cmd_echo` (bit 29 flipped) → `rsp_err`=1.
- RUN N=0 → `rsp_valid` at T+1, pipeline_en never asserted. RUN N=7 → pipeline_en high for exactly 7 cycles.
- CPU_RESET → bit 28 high for exactly 4 cycles. The CPU pc and registers read back as 0 in a following run.
- Back-to-back: WRITE accepted in the same cycle as the previous `rsp_valid` → no idle bubble. A scoreboard checks that req and pipeline_en are never both 1.
